// File: rtl/cpx_divide.sv
// cpx_divide: iterative complex divider (x / y) with saturated fixed-point I/Q result.
// Define CPX_DIVIDE_ROUND_EN for round-half-away-from-zero instead of truncation.
module cpx_divide #(
   parameter int x_bits    = 12,
   parameter int y_bits    = 12,
   parameter int out_bits  = 16,
   parameter int frac_bits = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       m_axis_x_tvalid,
   input  logic signed [x_bits-1:0]   xi,
   input  logic signed [x_bits-1:0]   xq,
   input  logic                       m_axis_y_tvalid,
   input  logic signed [y_bits-1:0]   yi,
   input  logic signed [y_bits-1:0]   yq,
   output logic                       m_axis_tready,
   output logic                       s_axis_i_tvalid,
   output logic signed [out_bits-1:0] i,
   output logic                       s_axis_q_tvalid,
   output logic signed [out_bits-1:0] q,
   input  logic                       s_axis_tready,
   output logic                       div_by_zero
);
   localparam int NW = x_bits + y_bits + 1;
   localparam int DW = 2 * y_bits + 1;
`ifdef CPX_DIVIDE_ROUND_EN
   localparam int LW = NW + frac_bits + 1;
`else
   localparam int LW = NW + frac_bits;
`endif
   localparam int CW = $clog2(LW);
   localparam logic [LW-1:0] MAXP = LW'(2 ** (out_bits - 1) - 1);
   localparam logic [LW-1:0] MINM = LW'(2 ** (out_bits - 1));

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
   state_t state, state_n;

   logic signed [x_bits-1:0] xi_r, xq_r;
   logic signed [y_bits-1:0] yi_r, yq_r;
   logic signed [NW-1:0]     ni, nq;
   logic [NW-1:0]            ai, aq;
   logic [DW-1:0]            den, den_r, ri, rq;
   logic [LW-1:0]            ei, eq, di, dq;
   logic                     si, sq, accept;
   logic [CW-1:0]            cnt;

   // One restoring step: remainder in the top DW bits, dividend/quotient shift register below.
   function automatic logic [DW+LW-1:0] step(input logic [DW-1:0] r, input logic [LW-1:0] d,
                                             input logic [DW-1:0] dn);
      logic [DW:0] t;
      logic        ge;
      t = {r, d[LW-1]};
      ge = t >= {1'b0, dn};
      step = {ge ? DW'(t - {1'b0, dn}) : t[DW-1:0], d[LW-2:0], ge};
   endfunction

   function automatic logic [out_bits-1:0] sat(input logic neg, input logic [LW-1:0] m);
      sat = neg ? (m >= MINM ? out_bits'(MINM) : out_bits'(-m))
                : (m > MAXP ? out_bits'(MAXP) : out_bits'(m));
   endfunction

   assign accept = m_axis_x_tvalid & m_axis_y_tvalid & m_axis_tready;
   assign s_axis_q_tvalid = s_axis_i_tvalid;

   always_comb begin
      ni = NW'(xi_r) * NW'(yi_r) + NW'(xq_r) * NW'(yq_r);
      nq = NW'(xq_r) * NW'(yi_r) - NW'(xi_r) * NW'(yq_r);
      den = DW'(yi_r) * DW'(yi_r) + DW'(yq_r) * DW'(yq_r);
      ai = ni[NW-1] ? -ni : ni;
      aq = nq[NW-1] ? -nq : nq;
`ifdef CPX_DIVIDE_ROUND_EN
      ei = LW'({ai, {frac_bits{1'b0}}}) + LW'(den >> 1);
      eq = LW'({aq, {frac_bits{1'b0}}}) + LW'(den >> 1);
`else
      ei = LW'({ai, {frac_bits{1'b0}}});
      eq = LW'({aq, {frac_bits{1'b0}}});
`endif
   end

   always_ff @(posedge clk) state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? MULT : IDLE;
         MULT:    state_n = den == '0 ? DONE : DIV;
         DIV:     state_n = cnt == CW'(LW - 1) ? DONE : DIV;
         DONE:    state_n = s_axis_i_tvalid & s_axis_tready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   always_comb m_axis_tready = state == IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axis_i_tvalid <= 1'b0;
         i <= '0;
         q <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               xi_r <= xi;
               xq_r <= xq;
               yi_r <= yi;
               yq_r <= yq;
            end
            MULT: begin
               den_r <= den;
               di <= ei;
               dq <= eq;
               ri <= '0;
               rq <= '0;
               si <= ni[NW-1];
               sq <= nq[NW-1];
               cnt <= '0;
               div_by_zero <= den == '0;
            end
            DIV: begin
               {ri, di} <= step(ri, di, den_r);
               {rq, dq} <= step(rq, dq, den_r);
               cnt <= cnt + CW'(1);
            end
            DONE: if (!s_axis_i_tvalid) begin
               s_axis_i_tvalid <= 1'b1;
               i <= div_by_zero ? '0 : sat(si, di);
               q <= div_by_zero ? '0 : sat(sq, dq);
            end else if (s_axis_tready) s_axis_i_tvalid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpx_divide.sv
// tb_cpx_divide: scoreboard bench for cpx_divide with directed, hand-computed vectors.
module tb_cpx_divide;
`ifdef CPX_DIVIDE_ROUND_EN
   localparam int LAT = 36;
   localparam int R23 = 171;
`else
   localparam int LAT = 35;
   localparam int R23 = 170;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic m_axis_x_tvalid = 1'b0, m_axis_y_tvalid = 1'b0, s_axis_tready = 1'b1;
   logic signed [11:0] xi = '0, xq = '0, yi = '0, yq = '0;
   logic m_axis_tready, s_axis_i_tvalid, s_axis_q_tvalid, div_by_zero;
   logic signed [15:0] i, q;

   typedef struct {int i; int q; int dbz; int lat; int acc;} exp_t;
   exp_t sb[$];
   int total = 0, bad = 0, cyc = 0;

   cpx_divide dut (
      .clk(clk), .rst(rst),
      .m_axis_x_tvalid(m_axis_x_tvalid), .xi(xi), .xq(xq),
      .m_axis_y_tvalid(m_axis_y_tvalid), .yi(yi), .yq(yq),
      .m_axis_tready(m_axis_tready),
      .s_axis_i_tvalid(s_axis_i_tvalid), .i(i),
      .s_axis_q_tvalid(s_axis_q_tvalid), .q(q),
      .s_axis_tready(s_axis_tready), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string n, input int a, input int r);
      total++;
      if (a != r) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", n, a, r);
      end
   endtask

   task automatic op(input int a, input int b, input int c, input int d,
                     input int ei, input int eq, input int ez, input int el);
      int n;
      exp_t e;
      @(posedge clk); #1;
      n = 0;
      while (!m_axis_tready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!m_axis_tready) chk("tready_timeout", 0, 1);
      xi = 12'(a); xq = 12'(b); yi = 12'(c); yq = 12'(d);
      m_axis_x_tvalid = 1'b1;
      m_axis_y_tvalid = 1'b1;
      @(posedge clk); #1;
      e.i = ei; e.q = eq; e.dbz = ez; e.lat = el; e.acc = cyc;
      sb.push_back(e);
      m_axis_x_tvalid = 1'b0;
      m_axis_y_tvalid = 1'b0;
   endtask

   int rise = 0;
   logic prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (s_axis_i_tvalid && !prev) rise = cyc;
      prev = s_axis_i_tvalid;
      if (s_axis_i_tvalid && s_axis_tready) begin
         if (sb.size() == 0) chk("unexpected_output", 1, 0);
         else begin
            e = sb.pop_front();
            chk("i", i, e.i);
            chk("q", q, e.q);
            chk("dbz", div_by_zero, e.dbz);
            chk("latency", rise - e.acc, e.lat);
            chk("q_tvalid", s_axis_q_tvalid, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, hq, n, seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", m_axis_tready, 1);
      chk("rst_tvalid", s_axis_i_tvalid, 0);
      chk("rst_i", i, 0);
      chk("rst_q", q, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;

      op(4, 0, 2, 0, 512, 0, 0, LAT);
      op(1, 1, 1, -1, 0, 256, 0, LAT);
      op(0, 6, 0, 3, 512, 0, 0, LAT);
      op(2, 0, 3, 0, R23, 0, 0, LAT);
      op(-2, 0, 3, 0, -R23, 0, 0, LAT);
      op(3, 4, 1, 2, 563, -102, 0, LAT);
      op(2047, 0, 1, 0, 32767, 0, 0, LAT);
      op(-2048, 0, 1, 0, -32768, 0, 0, LAT);
      op(5, -3, 0, 0, 0, 0, 1, 2);
      op(6, 0, 3, 0, 512, 0, 0, LAT);

      // back-pressure: result must hold and new operands must be ignored
      while (!m_axis_tready) begin
         @(posedge clk); #1;
      end
      s_axis_tready = 1'b0;
      op(4, 0, 2, 0, 512, 0, 0, LAT);
      n = 0;
      while (!s_axis_i_tvalid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_valid", s_axis_i_tvalid, 1);
      hi = i;
      hq = q;
      for (int k = 0; k < 10; k++) begin
         xi = 12'(7); yi = 12'(1);
         m_axis_x_tvalid = 1'b1;
         m_axis_y_tvalid = 1'b1;
         @(posedge clk); #1;
         chk("hold_i", i, hi);
         chk("hold_q", q, hq);
         chk("hold_valid", s_axis_i_tvalid, 1);
         chk("hold_tready", m_axis_tready, 0);
      end
      m_axis_x_tvalid = 1'b0;
      m_axis_y_tvalid = 1'b0;
      s_axis_tready = 1'b1;

      // reset during DIV abandons the operation
      op(4, 0, 2, 0, 512, 0, 0, LAT);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      chk("midrst_tready", m_axis_tready, 1);
      chk("midrst_tvalid", s_axis_i_tvalid, 0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (s_axis_i_tvalid) seen = 1;
      end
      chk("midrst_no_output", seen, 0);
      op(3, 4, 1, 2, 563, -102, 0, LAT);

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
